esc_drv: RTL and testbench
==========================

ESC_DRV -- requirements
Module: esc_drv

Interface
REQ-001 SHALL have parameter PER_W, default 20: period counter width; frame = 2^PER_W clocks.
REQ-002 SHALL have parameter BASE_CNT, default 6250: pulse width in clocks at speed 0.
REQ-003 SHALL have parameter SLEW, default 32: max per-frame increase of an applied speed.
REQ-004 SHALL have parameter ARM_FRAMES, default 25: zero-speed frames sent before running.
REQ-005 SHALL have one clock and one reset. The reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock, all flops on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 arm  input  1  request to run motors; sampled only at frame start.
REQ-009 frnt_spd, bck_spd, lft_spd, rght_spd  input  11 each  unsigned commanded speeds from flight control.
REQ-010 frnt, bck, lft, rght  output  1 each  registered PWM pulse to each ESC.
REQ-011 frm_strt  output  1  registered one-cycle pulse marking frame start.
REQ-012 armed  output  1  registered; high only in RUN state.

Function
REQ-013 SHALL keep a free-running PER_W-bit counter cnt, incrementing every clock, wrapping from all-ones to 0.
REQ-014 "Frame edge" SHALL mean the clock edge at which cnt goes from all-ones to 0; frm_strt SHALL be high for exactly the cycle following each frame edge.
REQ-015 SHALL hold a 11-bit applied speed per motor; it SHALL change only at frame edges.
REQ-016 Pulse width per motor SHALL be BASE_CNT + 3*applied, computed in 14 bits without overflow (max 12391).
REQ-017 Each PWM output SHALL be set at every frame edge and cleared at the edge where cnt equals width-1, giving exactly width high cycles, cnt 0..width-1.
REQ-018 Width compare SHALL use the applied speed updated at the same frame edge.
REQ-019 State machine SHALL have states DISARMED, ARMING, RUN, evaluated at frame edges only.
REQ-020 DISARMED: applied speeds forced to 0; arm=1 at frame edge -> ARMING, frame counter cleared.
REQ-021 ARMING: applied speeds 0; after ARM_FRAMES frames in ARMING -> RUN; arm=0 at any frame edge -> DISARMED.
REQ-022 RUN: at each frame edge, per motor, if commanded > applied, applied += min(SLEW, commanded-applied); if commanded <= applied, applied = commanded immediately.
REQ-023 RUN: arm=0 at frame edge -> DISARMED, with applied speeds forced to 0 at that same edge.
REQ-024 Changes to arm or commanded speeds between frame edges SHALL NOT affect the current frame's pulses.
REQ-025 Motors SHALL slew independently; simultaneous different commands SHALL not interact.
REQ-026 armed SHALL reflect the state after each frame edge.

Reset
REQ-027 rst high SHALL immediately force cnt=0, state DISARMED, frame counter 0, applied speeds 0, all PWM outputs 0, frm_strt 0, armed 0.
REQ-028 Reset asserted mid-pulse SHALL drop PWM outputs at once; no pulse is emitted until the first frame edge after rst deasserts (2^PER_W clocks later).
REQ-029 No output SHALL glitch high during or on exit from reset.

Verification (PER_W=16, ARM_FRAMES=2, SLEW=32, BASE_CNT=6250)
REQ-030 Reset asserted at cnt=100 during a pulse -> all PWM 0 same cycle; first frm_strt 65536 clocks after release.
REQ-031 arm=0, all spd=400 -> every pulse exactly 6250 clocks; armed stays 0.
REQ-032 arm=1 before frame edge, frnt_spd=256 -> frames 1-2 width 6250, frame 3 width 6346, +96 per frame, frame 10 onward 7018; armed high from frame 3.
REQ-033 In RUN at frnt applied 256, frnt_spd changed to 0 mid-frame -> current frame 7018, next frame 6250.
REQ-034 In RUN, frnt_spd=0x7FF, lft_spd=0 -> frnt ramps 96 clocks/frame to 12391 (reached frame 64 of RUN, capped at 2047 not 2048); lft stays 6250.
REQ-035 arm dropped mid-frame in RUN with applied 256 -> current frame 7018, next frame 6250, armed 0; re-arm requires ARM_FRAMES zero frames again.

Source files
------------

// File: rtl/esc_if.sv
// esc_if: ESC driver bundle -- arm and four 11-bit speed commands in; four PWM pulses, frm_strt and armed out
interface esc_if;
  logic arm;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic frnt, bck, lft, rght;
  logic frm_strt, armed;
  modport master(output arm, frnt_spd, bck_spd, lft_spd, rght_spd, input frnt, bck, lft, rght, frm_strt, armed);
  modport slave(input arm, frnt_spd, bck_spd, lft_spd, rght_spd, output frnt, bck, lft, rght, frm_strt, armed);
endinterface

// File: rtl/esc_drv.sv
// esc_drv: 4-channel ESC PWM driver (clk, async rst, esc_if.slave bus) with arming sequence and per-frame slew-limited speeds
module esc_drv #(
  parameter int PER_W = 20,
  parameter int BASE_CNT = 6250,
  parameter int SLEW = 32,
  parameter int ARM_FRAMES = 25
) (
  input logic clk,
  input logic rst,
  esc_if.slave bus
);
  localparam int FC_W = ARM_FRAMES > 1 ? $clog2(ARM_FRAMES) : 1;
  typedef enum logic [1:0] {DISARMED, ARMING, RUN} state_t;
  state_t st, st_d;
  logic [PER_W-1:0] cnt;
  logic [FC_W-1:0] fc, fc_d;
  logic [10:0] cmd [4];
  logic [10:0] app [4];
  logic [10:0] app_d [4];
  logic [10:0] dif [4];
  logic [13:0] wid [4];
  logic [3:0] pwm;
  logic frm_strt, armed, fe;
  assign fe = &cnt;
  assign cmd[0] = bus.frnt_spd;
  assign cmd[1] = bus.bck_spd;
  assign cmd[2] = bus.lft_spd;
  assign cmd[3] = bus.rght_spd;
  assign bus.frnt = pwm[0];
  assign bus.bck = pwm[1];
  assign bus.lft = pwm[2];
  assign bus.rght = pwm[3];
  assign bus.frm_strt = frm_strt;
  assign bus.armed = armed;
  always_comb begin
    st_d = st;
    fc_d = fc;
    if (fe)
      case (st)
        DISARMED: begin
          st_d = bus.arm ? ARMING : DISARMED;
          fc_d = '0;
        end
        ARMING: begin
          st_d = !bus.arm ? DISARMED : (int'(fc) == ARM_FRAMES - 1) ? RUN : ARMING;
          fc_d = fc + 1'b1;
        end
        default: st_d = bus.arm ? RUN : DISARMED;
      endcase
  end
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dif[i] = cmd[i] - app[i];
      app_d[i] = !fe ? app[i] :
                 st_d != RUN ? '0 :
                 cmd[i] <= app[i] ? cmd[i] :
                 int'(dif[i]) > SLEW ? app[i] + 11'(SLEW) : cmd[i];
      wid[i] = 14'(BASE_CNT) + 14'(app[i]) * 14'd3;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      st <= DISARMED;
      fc <= '0;
      app <= '{default: '0};
      pwm <= '0;
      frm_strt <= 1'b0;
      armed <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      st <= st_d;
      fc <= fc_d;
      app <= app_d;
      frm_strt <= fe;
      armed <= st_d == RUN;
      for (int i = 0; i < 4; i++)
        pwm[i] <= fe | (pwm[i] & (32'(cnt) != 32'(wid[i]) - 32'd1));
    end
endmodule

// File: tb/tb_esc_drv.sv
// tb_esc_drv: scoreboard bench for esc_drv -- per-frame expected pulse widths and armed, plus reset behaviour
module tb_esc_drv;
  localparam int PW = 13;
  localparam int F = 1 << PW;
  typedef struct packed {
    logic a;
    logic [3:0][13:0] w;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  always #5 clk = ~clk;
  esc_if bus();
  esc_drv #(.PER_W(PW), .BASE_CNT(50), .SLEW(512), .ARM_FRAMES(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  function automatic int pwms();
    return int'({bus.rght, bus.lft, bus.bck, bus.frnt});
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic drive(input logic a, input int f, input int b, input int l, input int r);
    bus.arm = a;
    bus.frnt_spd = 11'(f);
    bus.bck_spd = 11'(b);
    bus.lft_spd = 11'(l);
    bus.rght_spd = 11'(r);
  endtask
  task automatic push(input logic a, input int f, input int b, input int l, input int r);
    exp_t e;
    e.a = a;
    e.w[0] = 14'(f);
    e.w[1] = 14'(b);
    e.w[2] = 14'(l);
    e.w[3] = 14'(r);
    sb.push_back(e);
  endtask
  task automatic wait_frm(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frm_strt && n < 2 * F);
    if (!bus.frm_strt) begin
      chk("frm_strt_timeout", n, F);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "no frame start within bound");
    end
  endtask
  initial begin : monitor
    exp_t e;
    int hc[4];
    int frm_no;
    logic in_frm, arm_s;
    logic [3:0] p;
    in_frm = 1'b0;
    arm_s = 1'b0;
    frm_no = 0;
    forever begin
      @(negedge clk);
      p = {bus.rght, bus.lft, bus.bck, bus.frnt};
      if (rst) in_frm = 1'b0;
      else if (bus.frm_strt) begin
        if (in_frm) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            frm_no++;
            chk($sformatf("f%0d_armed", frm_no), int'(arm_s), int'(e.a));
            for (int i = 0; i < 4; i++) chk($sformatf("f%0d_w%0d", frm_no, i), hc[i], int'(e.w[i]));
          end
        end
        in_frm = 1'b1;
        arm_s = bus.armed;
        for (int i = 0; i < 4; i++) hc[i] = int'(p[i]);
      end else if (in_frm)
        for (int i = 0; i < 4; i++) hc[i] += int'(p[i]);
    end
  end
  initial begin : stim
    int n, bad;
    rst = 1'b1;
    drive(1'b1, 2047, 600, 0, 100);
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwms(), 0);
    chk("rst_frm_strt", int'(bus.frm_strt), 0);
    chk("rst_armed", int'(bus.armed), 0);
    push(1'b0, 50, 50, 50, 50);
    rst = 1'b0;
    wait_frm(n);
    chk("first_frame_latency", n, F);
    repeat (100) @(negedge clk);
    push(1'b0, 50, 50, 50, 50);
    wait_frm(n);
    repeat (100) @(negedge clk);
    push(1'b1, 1586, 1586, 50, 350);
    wait_frm(n);
    repeat (100) @(negedge clk);
    push(1'b1, 3122, 1850, 50, 350);
    wait_frm(n);
    repeat (100) @(negedge clk);
    drive(1'b1, 2047, 300, 0, 0);
    push(1'b1, 4658, 950, 50, 50);
    wait_frm(n);
    repeat (100) @(negedge clk);
    drive(1'b1, 2047, 300, 40, 0);
    push(1'b1, 6191, 950, 170, 50);
    wait_frm(n);
    repeat (100) @(negedge clk);
    bus.arm = 1'b0;
    push(1'b0, 50, 50, 50, 50);
    wait_frm(n);
    repeat (100) @(negedge clk);
    bus.arm = 1'b1;
    push(1'b0, 50, 50, 50, 50);
    wait_frm(n);
    wait_frm(n);
    chk("rearm_second_frame_armed", int'(bus.armed), 0);
    repeat (20) @(negedge clk);
    chk("pulse_before_rst", int'(bus.frnt), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_pulse_pwm", pwms(), 0);
    chk("rst_mid_pulse_frm_strt", int'(bus.frm_strt), 0);
    chk("rst_mid_pulse_armed", int'(bus.armed), 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.frm_strt && pwms() != 0) bad++;
    end while (!bus.frm_strt && n < 2 * F);
    chk("no_pulse_before_first_edge", bad, 0);
    chk("rst_release_latency", n, F);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
